// File: rtl/input_port_pkg.sv
// -----------------------------------------------------------------------------
// input_port_pkg
// Purpose : Shared constants and types for the input port buffer.
// Contents: default word width and depth, pointer/count widths derived from the
//           default depth, and the datapath word type.
// -----------------------------------------------------------------------------
package input_port_pkg;

    localparam int unsigned DATA_W_DEFAULT = 16;
    localparam int unsigned DEPTH_DEFAULT  = 4;
    localparam int unsigned PTR_W          = $clog2(DEPTH_DEFAULT);
    localparam int unsigned CNT_W          = PTR_W + 1;

    typedef logic [DATA_W_DEFAULT-1:0] word_t;

endpackage : input_port_pkg

// File: rtl/sync_fifo_core.sv
// -----------------------------------------------------------------------------
// sync_fifo_core
// Purpose : Synchronous FIFO storage with pointers and an occupancy counter.
//           Full/empty are decided from the counter, never from the pointers.
// Ports   : clock    - system clock, rising edge
//           reset    - synchronous active-high reset of the control state
//           i_push   - write i_wdata (ignored when full)
//           i_pop    - advance the head (ignored when empty)
//           i_wdata  - word to store
//           o_head   - oldest stored word
//           o_full   - count == DEPTH
//           o_empty  - count == 0
//           o_count  - occupancy, 0..DEPTH
// -----------------------------------------------------------------------------
module sync_fifo_core
    import input_port_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEFAULT,
    parameter int unsigned DEPTH  = DEPTH_DEFAULT
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [DATA_W-1:0]          i_wdata,
    output logic [DATA_W-1:0]          o_head,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH):0]     o_count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]     r_wptr;
    logic [PW-1:0]     r_rptr;
    logic [CW-1:0]     r_count;

    logic w_do_push;
    logic w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign w_do_push = i_push & ~o_full;
    assign w_do_pop  = i_pop & ~o_empty;
    assign o_head    = r_mem[r_rptr];
    assign o_count   = r_count;

    // Storage is deliberately not reset.
    always_ff @(posedge clock) begin
        if (w_do_push && !reset) begin
            r_mem[r_wptr] <= i_wdata;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_wptr <= r_wptr + PW'(1);
            end
            if (w_do_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : sync_fifo_core

// File: rtl/input_port_buffer.sv
// -----------------------------------------------------------------------------
// input_port_buffer
// Purpose : Buffers words from an external device (valid/ready) and hands one
//           word to the datapath per control-unit read request.
// Config  : INPUT_PORT_STROBE_EDGE_EN - when defined, a read request is the
//           rising edge of input_read; otherwise input_read is level-sensitive.
// Ports   : clock      - system clock, rising edge
//           reset      - synchronous active-high reset
//           ext_data   - word offered by the external device
//           ext_valid  - ext_data valid this cycle
//           ext_ready  - buffer can accept a word (from count only)
//           input_read - control-unit read strobe
//           data_out   - last word delivered (registered, 0 after empty read)
//           data_avail - FIFO not empty
//           count      - occupancy, 0..DEPTH
//           underflow  - sticky: a read was attempted while empty
// -----------------------------------------------------------------------------
module input_port_buffer
    import input_port_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEFAULT,
    parameter int unsigned DEPTH  = DEPTH_DEFAULT
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [DATA_W-1:0]      ext_data,
    input  logic                   ext_valid,
    output logic                   ext_ready,
    input  logic                   input_read,
    output logic [DATA_W-1:0]      data_out,
    output logic                   data_avail,
    output logic [$clog2(DEPTH):0] count,
    output logic                   underflow
);

    logic [DATA_W-1:0]      w_head;
    logic                   w_full;
    logic                   w_empty;
    logic                   w_req;
    logic                   w_push;
    logic [$clog2(DEPTH):0] w_count;

    logic [DATA_W-1:0]      r_data_out;
    logic                   r_underflow;

`ifdef INPUT_PORT_STROBE_EDGE_EN
    logic r_read_q;

    // Resetting to 0 makes a strobe held across reset release count as an edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_read_q <= 1'b0;
        end else begin
            r_read_q <= input_read;
        end
    end

    assign w_req = input_read & ~r_read_q;
`else
    assign w_req = input_read;
`endif

    assign w_push = ext_valid & ~w_full;

    sync_fifo_core #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .i_push  (w_push),
        .i_pop   (w_req),
        .i_wdata (ext_data),
        .o_head  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    // No bypass: a read on an empty FIFO yields 0 even if a push lands this edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_data_out  <= '0;
            r_underflow <= 1'b0;
        end else if (w_req) begin
            if (w_empty) begin
                r_data_out  <= '0;
                r_underflow <= 1'b1;
            end else begin
                r_data_out <= w_head;
            end
        end
    end

    assign ext_ready  = ~w_full;
    assign data_avail = ~w_empty;
    assign count      = w_count;
    assign data_out   = r_data_out;
    assign underflow  = r_underflow;

endmodule : input_port_buffer

// File: tb/tb_input_port_buffer.sv
// -----------------------------------------------------------------------------
// tb_input_port_buffer
// Directed sequence followed by random traffic, checked against a queue-based
// model of the buffer. Build with INPUT_PORT_STROBE_EDGE_EN to check the
// edge-detected read strobe.
// -----------------------------------------------------------------------------
module tb_input_port_buffer;
    import input_port_pkg::*;

    localparam int unsigned DEPTH = DEPTH_DEFAULT;

    logic        clock;
    logic        reset;
    word_t       ext_data;
    logic        ext_valid;
    logic        ext_ready;
    logic        input_read;
    word_t       data_out;
    logic        data_avail;
    logic [CNT_W-1:0] count;
    logic        underflow;

    int vectors;
    int miscompares;

    // Reference model state
    word_t m_q[$];
    word_t m_out;
    bit    m_uf;
    bit    m_prev_rd;

    input_port_buffer dut (
        .clock      (clock),
        .reset      (reset),
        .ext_data   (ext_data),
        .ext_valid  (ext_valid),
        .ext_ready  (ext_ready),
        .input_read (input_read),
        .data_out   (data_out),
        .data_avail (data_avail),
        .count      (count),
        .underflow  (underflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_all();
        chk("data_out", 32'(data_out), 32'(m_out));
        chk("count", 32'(count), 32'(m_q.size()));
        chk("data_avail", 32'(data_avail), 32'(m_q.size() != 0));
        chk("underflow", 32'(underflow), 32'(m_uf));
        chk("ext_ready", 32'(ext_ready), 32'(m_q.size() != DEPTH));
    endtask

    // Apply one cycle of stimulus, advance the model, then check outputs.
    task automatic cycle(input bit v, input word_t d, input bit rd);
        bit req;
        bit acc;
        ext_valid  = v;
        ext_data   = d;
        input_read = rd;
        #1;
        chk("ext_ready_pre", 32'(ext_ready), 32'(m_q.size() != DEPTH));
`ifdef INPUT_PORT_STROBE_EDGE_EN
        req = rd && !m_prev_rd;
`else
        req = rd;
`endif
        acc = v && (m_q.size() < DEPTH);
        if (req) begin
            if (m_q.size() > 0) begin
                m_out = m_q.pop_front();
            end else begin
                m_out = '0;
                m_uf  = 1'b1;
            end
        end
        if (acc) m_q.push_back(d);
        m_prev_rd = rd;
        @(posedge clock);
        #1;
        chk_all();
    endtask

    task automatic do_reset(input bit rd);
        reset      = 1'b1;
        ext_valid  = 1'b1;
        ext_data   = 16'hDEAD;
        input_read = rd;
        @(posedge clock);
        #1;
        reset     = 1'b0;
        m_q.delete();
        m_out     = '0;
        m_uf      = 1'b0;
        m_prev_rd = 1'b0;
        chk_all();
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        reset       = 1'b1;
        ext_valid   = 1'b0;
        ext_data    = '0;
        input_read  = 1'b0;
        @(posedge clock);
        #1;

        // Reset then idle
        do_reset(1'b0);
        cycle(0, 16'h0, 0);

        // Order and latency
        cycle(1, 16'h1234, 0);
        cycle(1, 16'hBEEF, 0);
        cycle(0, 16'h0, 1);
        chk("first_word", 32'(data_out), 32'h1234);
        cycle(0, 16'h0, 0);
        cycle(0, 16'h0, 1);
        chk("second_word", 32'(data_out), 32'hBEEF);
        chk("drained", 32'(count), 32'd0);
        cycle(0, 16'h0, 0);

        // Full, with pointer wrap
        for (int k = 1; k <= 4; k++) cycle(1, word_t'(k), 0);
        chk("full_ready", 32'(ext_ready), 32'd0);
        cycle(1, 16'h0005, 0);
        chk("full_count", 32'(count), 32'd4);
        cycle(1, 16'h0005, 1);
        chk("pop_at_full", 32'(data_out), 32'h0001);
        cycle(1, 16'h0005, 0);
        chk("late_push", 32'(count), 32'd4);
        for (int k = 2; k <= 5; k++) begin
            cycle(0, 16'h0, 1);
            chk("wrap_order", 32'(data_out), 32'(k));
            cycle(0, 16'h0, 0);
        end

        // Empty read, underflow is sticky
        cycle(0, 16'h0, 1);
        chk("empty_out", 32'(data_out), 32'd0);
        chk("empty_uf", 32'(underflow), 32'd1);
        cycle(0, 16'h0, 0);
        cycle(1, 16'h00AA, 0);
        cycle(0, 16'h0, 1);
        chk("after_uf", 32'(data_out), 32'h00AA);
        chk("uf_sticky", 32'(underflow), 32'd1);
        cycle(0, 16'h0, 0);

        // Simultaneous push/pop on empty: no bypass
        cycle(1, 16'h0BB0, 1);
        chk("no_bypass", 32'(data_out), 32'd0);
        chk("push_on_empty", 32'(count), 32'd1);
        cycle(0, 16'h0, 0);

        // Simultaneous push/pop at count 2
        cycle(1, 16'h0CC0, 0);
        cycle(1, 16'h0DD0, 1);
        chk("pp_count", 32'(count), 32'd2);
        chk("pp_oldest", 32'(data_out), 32'h0BB0);
        cycle(0, 16'h0, 0);

        // Strobe held for three cycles with three words queued
        do_reset(1'b0);
        for (int k = 0; k < 3; k++) cycle(1, word_t'(16'h0100 + k), 0);
        for (int k = 0; k < 3; k++) cycle(0, 16'h0, 1);
`ifdef INPUT_PORT_STROBE_EDGE_EN
        chk("hold_count", 32'(count), 32'd2);
`else
        chk("hold_count", 32'(count), 32'd0);
`endif
        cycle(0, 16'h0, 0);

        // Reset mid-sequence with strobe held through release
        for (int k = 0; k < 3; k++) cycle(1, word_t'(16'h0200 + k), 0);
        cycle(0, 16'h0, 1);
        do_reset(1'b1);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_out", 32'(data_out), 32'd0);
        cycle(0, 16'h0, 1);
        cycle(0, 16'h0, 0);

        // Random traffic
        do_reset(1'b0);
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 63) == 0) begin
                do_reset(1'($urandom_range(0, 1)));
            end else begin
                cycle(1'($urandom_range(0, 1)), word_t'($urandom),
                      ($urandom_range(0, 2) == 0));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule : tb_input_port_buffer
